// File: rtl/seven_seg_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | seven_seg_pkg: shared segment patterns, anode and blink-mode codes    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package seven_seg_pkg;

  // Active-low gfedcba patterns for the displayable digits
  localparam logic [6:0] c_seg_0 = 7'b1000000;
  localparam logic [6:0] c_seg_1 = 7'b1111001;
  localparam logic [6:0] c_seg_2 = 7'b0100100;
  localparam logic [6:0] c_seg_3 = 7'b0110000;
  localparam logic [6:0] c_seg_4 = 7'b0011001;
  localparam logic [6:0] c_seg_5 = 7'b0010010;
  localparam logic [6:0] c_seg_6 = 7'b0000010;
  localparam logic [6:0] c_seg_7 = 7'b1111000;
  localparam logic [6:0] c_seg_8 = 7'b0000000;
  localparam logic [6:0] c_seg_9 = 7'b0011000;

  localparam logic [3:0] c_anode_blank = 4'b1111;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_ON   = 2'b01,
    MODE_05HZ = 2'b10,
    MODE_1HZ  = 2'b11
  } mode_e;

  // Driver ROM: codes above 9 render as a fully lit digit
  function automatic logic [6:0] seg_encode(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'd0:    pat = c_seg_0;
      4'd1:    pat = c_seg_1;
      4'd2:    pat = c_seg_2;
      4'd3:    pat = c_seg_3;
      4'd4:    pat = c_seg_4;
      4'd5:    pat = c_seg_5;
      4'd6:    pat = c_seg_6;
      4'd7:    pat = c_seg_7;
      4'd9:    pat = c_seg_9;
      default: pat = c_seg_8;
    endcase
    return pat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_decode.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | seven_seg_decode: active-low segment pattern to digit code            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       hit,
  output logic [3:0] code
);

  always_comb begin
    hit  = 1'b1;
    code = 4'd0;
    case (pattern)
      c_seg_0: code = 4'd0;
      c_seg_1: code = 4'd1;
      c_seg_2: code = 4'd2;
      c_seg_3: code = 4'd3;
      c_seg_4: code = 4'd4;
      c_seg_5: code = 4'd5;
      c_seg_6: code = 4'd6;
      c_seg_7: code = 4'd7;
      c_seg_8: code = 4'd8;
      c_seg_9: code = 4'd9;
      default: hit  = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seven_seg_capture.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | seven_seg_capture: recovers digits and blink mode from display pins   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CNT = 3,
  parameter int WIN_LEN    = 50_000_000
)(
  input  logic       f_clk,
  input  logic       rst_n,
  input  logic [3:0] anode,
  input  logic [6:0] cathodes,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] digit4,
  output logic [3:0] valid,
  output logic [3:0] seg_err,
  output logic       multi_err,
  output logic       update,
  output logic [1:0] mode_det,
  output logic       mode_valid
);

  localparam int RUN_W = $clog2(STABLE_CNT + 1);
  localparam int WIN_W = $clog2(WIN_LEN + 1);
  localparam logic [RUN_W-1:0] c_run_max  = RUN_W'(STABLE_CNT);
  localparam logic [RUN_W-1:0] c_run_pre  = RUN_W'(STABLE_CNT - 1);
  localparam logic [WIN_W-1:0] c_win_last = WIN_W'(WIN_LEN - 1);
  localparam logic [WIN_W-1:0] c_lit_thr  = WIN_W'(WIN_LEN / 8);

  logic [10:0]      r_sync1, r_sync2, r_prev;
  logic [1:0]       r_primed;
  logic [RUN_W-1:0] r_run;
  logic             w_match, w_accept;
  logic [3:0]       w_anode, w_sel;
  logic [6:0]       w_cath;
  logic             w_blank, w_single, w_hit;
  logic [3:0]       w_code;

  logic [3:0]       r_digit [4];
  logic [3:0]       r_valid, r_seg_err;
  logic             r_multi_err, r_update, r_lit_state;

  logic [WIN_W-1:0] r_win, r_lit, w_lit_sum;
  logic [3:0]       r_hist;
  logic [2:0]       r_nwin;
  logic             r_win_end, r_mode_valid;
  mode_e            r_mode, w_mode_next;

  // r_primed masks the two cycles where the synchronizer still holds reset zeros
  always_ff @(posedge f_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_primed <= '0;
    end else begin
      r_sync1  <= {anode, cathodes};
      r_sync2  <= r_sync1;
      r_primed <= {r_primed[0], 1'b1};
    end
  end

  assign w_match  = (r_sync2 == r_prev);
  assign w_accept = r_primed[1] && w_match && (r_run == c_run_pre);

  always_ff @(posedge f_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= '0;
      r_run  <= '0;
    end else if (r_primed[1]) begin
      r_prev <= r_sync2;
      if (r_run == '0 || !w_match) begin
        r_run <= RUN_W'(1);
      end else if (r_run != c_run_max) begin
        r_run <= r_run + 1'b1;
      end
    end
  end

  assign w_anode  = r_sync2[10:7];
  assign w_cath   = r_sync2[6:0];
  assign w_sel    = ~w_anode;
  assign w_blank  = (w_anode == c_anode_blank);
  assign w_single = (w_sel != 4'd0) && ((w_sel & (w_sel - 4'd1)) == 4'd0);

  seven_seg_decode u_decode (
    .pattern (w_cath),
    .hit     (w_hit),
    .code    (w_code)
  );

  always_ff @(posedge f_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_digit[i] <= 4'd0;
      r_valid     <= '0;
      r_seg_err   <= '0;
      r_multi_err <= 1'b0;
      r_update    <= 1'b0;
      r_lit_state <= 1'b0;
    end else begin
      r_update <= w_accept && w_single && w_hit;
      if (w_accept) begin
        r_lit_state <= w_single;
        if (!w_blank && !w_single) r_multi_err <= 1'b1;
        for (int i = 0; i < 4; i++) begin
          if (w_single && w_sel[i]) begin
            if (w_hit) begin
              r_digit[i] <= w_code;
              r_valid[i] <= 1'b1;
            end else begin
              r_seg_err[i] <= 1'b1;
            end
          end
        end
      end
    end
  end

  // Blink classifier: the final cycle's lit contribution is folded in before the clear
  assign w_lit_sum = r_lit + WIN_W'(r_lit_state);

  always_ff @(posedge f_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win     <= '0;
      r_lit     <= '0;
      r_hist    <= '0;
      r_nwin    <= '0;
      r_win_end <= 1'b0;
    end else begin
      r_win_end <= 1'b0;
      if (r_win == c_win_last) begin
        r_win     <= '0;
        r_lit     <= '0;
        r_hist    <= {r_hist[2:0], (w_lit_sum >= c_lit_thr)};
        r_win_end <= 1'b1;
        if (r_nwin != 3'd4) r_nwin <= r_nwin + 3'd1;
      end else begin
        r_win <= r_win + 1'b1;
        r_lit <= w_lit_sum;
      end
    end
  end

  always_comb begin
    w_mode_next = r_mode;
    case (r_hist)
      4'b1111:                            w_mode_next = MODE_ON;
      4'b0000:                            w_mode_next = MODE_OFF;
      4'b0101, 4'b1010:                   w_mode_next = MODE_1HZ;
      4'b0011, 4'b0110, 4'b1100, 4'b1001: w_mode_next = MODE_05HZ;
      default:                            ;
    endcase
  end

  always_ff @(posedge f_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode       <= MODE_OFF;
      r_mode_valid <= 1'b0;
    end else if (r_win_end) begin
      r_mode <= w_mode_next;
      if (r_nwin == 3'd4) r_mode_valid <= 1'b1;
    end
  end

  assign digit1     = r_digit[0];
  assign digit2     = r_digit[1];
  assign digit3     = r_digit[2];
  assign digit4     = r_digit[3];
  assign valid      = r_valid;
  assign seg_err    = r_seg_err;
  assign multi_err  = r_multi_err;
  assign update     = r_update;
  assign mode_det   = r_mode;
  assign mode_valid = r_mode_valid;

endmodule
`default_nettype wire
